// File: rtl/stream_dispatch.sv
// Packet-to-flow dispatcher: maps each packet's key to a flow-table slot and replays
// the packet bytes to the matchers with fixed load/char/eop timing.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | wait for a sop beat; non-sop beats are dropped and counted
//   LOOKUP | parallel key compare; allocate (or evict) on a miss
//   LOAD   | one-cycle load_state pulse, new_stream_id on a fresh flow
//   GAP    | idle cycle so the first byte lands 2 cycles after load_state
//   STREAM | forward bytes to the matchers; last_q marks the final byte cycle
//   DRAIN  | wait out the matcher pipeline before committing
//   EOP    | one-cycle eop pulse
module stream_dispatch #(
    parameter int EOP_DELAY   = 3,
    parameter int NUM_STREAMS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld_i,
    output logic        in_ready_o,
    input  logic [7:0]  in_data_i,
    input  logic        in_sop_i,
    input  logic        in_eop_i,
    input  logic [31:0] in_key_i,
    output logic        load_state_o,
    output logic        new_stream_id_o,
    output logic [5:0]  stream_id_o,
    output logic [7:0]  char_in_o,
    output logic        char_in_vld_o,
    output logic        eop_o,
    output logic        table_full_o,
    output logic [15:0] drop_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_LOAD,
        S_GAP,
        S_STREAM,
        S_DRAIN,
        S_EOP
    } state_e;

    state_e state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;

    logic [31:0] key_stash_q;
    logic [7:0]  data_stash_q;
    logic        eop_stash_q;

    logic [NUM_STREAMS-1:0] valid_q, valid_d;
    logic [31:0]            key_q [NUM_STREAMS];
    logic [5:0]             alloc_ptr_q;
    logic                   hit;
    logic [5:0]             hit_idx;

    logic        in_ready_q, in_ready_d;
    logic        load_state_q, load_state_d;
    logic        new_stream_id_q, new_stream_id_d;
    logic [5:0]  stream_id_q, stream_id_d;
    logic [7:0]  char_in_q, char_in_d;
    logic        char_in_vld_q, char_in_vld_d;
    logic        eop_q, eop_d;
    logic        table_full_q;
    logic [15:0] drop_count_q;

    logic accept;
    logic do_alloc;

    assign accept   = in_vld_i & in_ready_q;
    assign do_alloc = (state_q == S_LOOKUP) && !hit;

    // Keys are unique in the table, so at most one entry can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (valid_q[i] && (key_q[i] == key_stash_q)) begin
                hit     = 1'b1;
                hit_idx = 6'(i);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (do_alloc) begin
            valid_d[alloc_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept && in_sop_i) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_LOAD;
            S_LOAD:   state_d = S_GAP;
            S_GAP: begin
                state_d = S_STREAM;
                last_d  = eop_stash_q;
            end
            S_STREAM: begin
                if (last_q) begin
                    state_d = S_DRAIN;
                    last_d  = 1'b0;
                    cnt_d   = 4'(EOP_DELAY - 1);
                end else if (accept && in_eop_i) begin
                    last_d = 1'b1;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_EOP;
                end
            end
            S_EOP:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next values for the registered outputs, derived from the upcoming state.
    always_comb begin
        in_ready_d      = (state_d == S_IDLE) || ((state_d == S_STREAM) && !last_d);
        load_state_d    = (state_d == S_LOAD);
        new_stream_id_d = do_alloc;
        eop_d           = (state_d == S_EOP);
        stream_id_d     = stream_id_q;
        if (state_q == S_LOOKUP) begin
            stream_id_d = hit ? hit_idx : alloc_ptr_q;
        end
        char_in_vld_d = 1'b0;
        char_in_d     = char_in_q;
        if (state_q == S_GAP) begin
            char_in_vld_d = 1'b1;
            char_in_d     = data_stash_q;
        end else if ((state_q == S_STREAM) && !last_q && accept) begin
            char_in_vld_d = 1'b1;
            char_in_d     = in_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_q      <= 1'b0;
            load_state_q    <= 1'b0;
            new_stream_id_q <= 1'b0;
            stream_id_q     <= '0;
            char_in_q       <= '0;
            char_in_vld_q   <= 1'b0;
            eop_q           <= 1'b0;
            table_full_q    <= 1'b0;
            drop_count_q    <= '0;
            valid_q         <= '0;
            alloc_ptr_q     <= '0;
            key_stash_q     <= '0;
            data_stash_q    <= '0;
            eop_stash_q     <= 1'b0;
        end else begin
            in_ready_q      <= in_ready_d;
            load_state_q    <= load_state_d;
            new_stream_id_q <= new_stream_id_d;
            stream_id_q     <= stream_id_d;
            char_in_q       <= char_in_d;
            char_in_vld_q   <= char_in_vld_d;
            eop_q           <= eop_d;
            table_full_q    <= &valid_d;
            valid_q         <= valid_d;
            if (do_alloc) begin
                alloc_ptr_q <= alloc_ptr_q + 6'd1;
            end
            if ((state_q == S_IDLE) && accept) begin
                if (in_sop_i) begin
                    key_stash_q  <= in_key_i;
                    data_stash_q <= in_data_i;
                    eop_stash_q  <= in_eop_i;
                end else begin
                    drop_count_q <= drop_count_q + 16'd1;
                end
            end
        end
    end

    // Key storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            key_q[alloc_ptr_q] <= key_stash_q;
        end
    end

    assign in_ready_o      = in_ready_q;
    assign load_state_o    = load_state_q;
    assign new_stream_id_o = new_stream_id_q;
    assign stream_id_o     = stream_id_q;
    assign char_in_o       = char_in_q;
    assign char_in_vld_o   = char_in_vld_q;
    assign eop_o           = eop_q;
    assign table_full_o    = table_full_q;
    assign drop_count_o    = drop_count_q;

endmodule

// File: tb/tb_stream_dispatch.sv
// Self-checking bench for stream_dispatch: directed and random packets compared against
// a flow-table model and the fixed load/char/eop timing rules.
module tb_stream_dispatch;

    localparam int EOP_D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_sop;
    logic        in_eop;
    logic [31:0] in_key;
    logic        load_state;
    logic        new_stream_id;
    logic [5:0]  stream_id;
    logic [7:0]  char_in;
    logic        char_in_vld;
    logic        eop;
    logic        table_full;
    logic [15:0] drop_count;

    stream_dispatch #(.EOP_DELAY(EOP_D), .NUM_STREAMS(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_vld_i       (in_vld),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .in_sop_i       (in_sop),
        .in_eop_i       (in_eop),
        .in_key_i       (in_key),
        .load_state_o   (load_state),
        .new_stream_id_o(new_stream_id),
        .stream_id_o    (stream_id),
        .char_in_o      (char_in),
        .char_in_vld_o  (char_in_vld),
        .eop_o          (eop),
        .table_full_o   (table_full),
        .drop_count_o   (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output event log, sampled mid-cycle.
    int          ld_cyc[$];
    logic        ld_new[$];
    logic [5:0]  ld_id[$];
    int          ch_cyc[$];
    logic [7:0]  ch_dat[$];
    int          eop_cyc[$];
    logic [5:0]  eop_id[$];
    int          collide = 0;

    always @(negedge clk) begin
        if (load_state === 1'b1) begin
            ld_cyc.push_back(cyc);
            ld_new.push_back(new_stream_id);
            ld_id.push_back(stream_id);
        end
        if (char_in_vld === 1'b1) begin
            ch_cyc.push_back(cyc);
            ch_dat.push_back(char_in);
        end
        if (eop === 1'b1) begin
            eop_cyc.push_back(cyc);
            eop_id.push_back(stream_id);
        end
        if (int'(load_state === 1'b1) + int'(eop === 1'b1) + int'(char_in_vld === 1'b1) > 1)
            collide++;
    end

    // Flow-table reference: plain key array with round-robin allocation.
    logic [31:0] m_key[64];
    bit          m_vld[64];
    int          m_ptr;
    int          m_drop;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
        m_ptr  = 0;
        m_drop = 0;
    endfunction

    function automatic void model_lookup(input logic [31:0] k, output int id, output bit isnew);
        isnew = 1'b1;
        id    = m_ptr;
        for (int i = 0; i < 64; i++) begin
            if (m_vld[i] && m_key[i] == k) begin
                id    = i;
                isnew = 1'b0;
            end
        end
        if (isnew) begin
            m_key[m_ptr] = k;
            m_vld[m_ptr] = 1'b1;
            m_ptr        = (m_ptr + 1) % 64;
        end
    endfunction

    function automatic bit model_full();
        bit f = 1'b1;
        for (int i = 0; i < 64; i++) if (!m_vld[i]) f = 1'b0;
        return f;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] pkt[$];
    int         acc[$];

    task automatic wait_acc();
        int t = 0;
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", 64'(t < 200), 64'(1));
        acc.push_back(cyc);
        @(negedge clk);
    endtask

    task automatic run_pkt(input logic [31:0] key, input int max_gap);
        int lb, cb, eb, t, n, g, exp_id, exp_c, last_c;
        bit exp_new, data_ok, time_ok;
        lb = ld_cyc.size();
        cb = ch_cyc.size();
        eb = eop_cyc.size();
        n  = pkt.size();
        acc.delete();
        model_lookup(key, exp_id, exp_new);
        for (int i = 0; i < n; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(32'(max_gap), 0)) : 0;
            in_vld = 1'b0;
            repeat (g) @(negedge clk);
            in_vld  = 1'b1;
            in_data = pkt[i];
            in_eop  = (i == n - 1);
            in_sop  = (i == 0) || (max_gap > 0 && $urandom_range(3, 0) == 0);
            in_key  = (i == 0) ? key : $urandom;
            wait_acc();
        end
        in_vld = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
        t = 0;
        while (eop_cyc.size() == eb && t < 150) begin
            @(negedge clk);
            t++;
        end
        chk("eop_timeout", 64'(t < 150), 64'(1));
        repeat (3) @(negedge clk);

        chk("load_count", 64'(ld_cyc.size() - lb), 64'(1));
        if (ld_cyc.size() > lb) begin
            chk("load_cycle", 64'(ld_cyc[lb]), 64'(acc[0] + 2));
            chk("new_stream_id", 64'(ld_new[lb]), 64'(exp_new));
            chk("load_stream_id", 64'(ld_id[lb]), 64'(exp_id));
        end
        chk("char_count", 64'(ch_cyc.size() - cb), 64'(n));
        data_ok = 1'b1;
        time_ok = 1'b1;
        for (int k = 0; k < n && cb + k < ch_cyc.size(); k++) begin
            exp_c = (k == 0) ? acc[0] + 4 : acc[k] + 1;
            if (ch_dat[cb + k] !== pkt[k]) data_ok = 1'b0;
            if (ch_cyc[cb + k] != exp_c) time_ok = 1'b0;
        end
        chk("char_data", 64'(data_ok), 64'(1));
        chk("char_timing", 64'(time_ok), 64'(1));
        last_c = (n == 1) ? acc[0] + 4 : acc[n - 1] + 1;
        chk("eop_count", 64'(eop_cyc.size() - eb), 64'(1));
        if (eop_cyc.size() > eb) begin
            chk("eop_cycle", 64'(eop_cyc[eb]), 64'(last_c + EOP_D));
            chk("eop_stream_id", 64'(eop_id[eb]), 64'(exp_id));
        end
        chk("table_full", 64'(table_full), 64'(model_full()));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pool[6];
        int lb, cb, eb, len;

        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        in_sop  = 1'b0;
        in_eop  = 1'b0;
        in_key  = '0;
        model_reset();
        repeat (3) @(negedge clk);

        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_load_state", 64'(load_state), 64'(0));
        chk("rst_new_stream_id", 64'(new_stream_id), 64'(0));
        chk("rst_char_in_vld", 64'(char_in_vld), 64'(0));
        chk("rst_eop", 64'(eop), 64'(0));
        chk("rst_table_full", 64'(table_full), 64'(0));
        chk("rst_stream_id", 64'(stream_id), 64'(0));
        chk("rst_char_in", 64'(char_in), 64'(0));
        chk("rst_drop_count", 64'(drop_count), 64'(0));

        rst_n = 1'b1;
        @(negedge clk);

        pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_pkt(32'hA5A5_0001, 0);
        chk("first_flow_id", 64'(ld_id[ld_id.size() - 1]), 64'(0));
        pkt = '{8'h55, 8'h66};
        run_pkt(32'hA5A5_0001, 0);
        pkt = '{8'h77, 8'h88, 8'h99};
        run_pkt(32'hA5A5_0002, 2);
        chk("second_flow_id", 64'(ld_id[ld_id.size() - 1]), 64'(1));

        // Non-sop beats in IDLE are dropped without touching the outputs.
        lb = ld_cyc.size();
        cb = ch_cyc.size();
        eb = eop_cyc.size();
        for (int i = 0; i < 3; i++) begin
            in_vld  = 1'b1;
            in_sop  = 1'b0;
            in_eop  = (i == 2);
            in_data = 8'(i + 8'hC0);
            in_key  = $urandom;
            wait_acc();
            m_drop++;
        end
        in_vld = 1'b0;
        in_eop = 1'b0;
        repeat (8) @(negedge clk);
        chk("drop_count_3", 64'(drop_count), 64'(3));
        chk("drop_no_outputs", 64'((ld_cyc.size() - lb) + (ch_cyc.size() - cb) + (eop_cyc.size() - eb)), 64'(0));

        for (int i = 0; i < 62; i++) begin
            pkt = '{8'(i)};
            run_pkt(32'h1000_0000 + 32'(i), 0);
        end
        chk("table_full_after_64", 64'(table_full), 64'(1));
        pkt = '{8'hE1, 8'hE2};
        run_pkt(32'hBEEF_0065, 0);
        chk("evict_id", 64'(ld_id[ld_id.size() - 1]), 64'(0));
        chk("evict_new", 64'(ld_new[ld_new.size() - 1]), 64'(1));
        pkt = '{8'hF0};
        run_pkt(32'hA5A5_0001, 0);
        chk("evicted_key_misses", 64'(ld_new[ld_new.size() - 1]), 64'(1));

        for (int i = 0; i < 6; i++) pool[i] = $urandom;
        for (int p = 0; p < 40; p++) begin
            pkt.delete();
            len = int'($urandom_range(6, 1));
            for (int k = 0; k < len; k++) pkt.push_back(8'($urandom));
            run_pkt(pool[$urandom_range(5, 0)], 3);
        end

        // Reset in the middle of STREAM abandons the packet.
        cb = ch_cyc.size();
        in_vld  = 1'b1;
        in_sop  = 1'b1;
        in_eop  = 1'b0;
        in_data = 8'h5A;
        in_key  = 32'hA5A5_0001;
        acc.delete();
        wait_acc();
        in_sop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        chk("stream_reached", 64'(ch_cyc.size() > cb), 64'(1));
        eb = eop_cyc.size();
        rst_n  = 1'b0;
        in_vld = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_char_in_vld", 64'(char_in_vld), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        rst_n = 1'b1;
        model_reset();
        repeat (20) @(negedge clk);
        chk("no_eop_after_reset", 64'(eop_cyc.size() - eb), 64'(0));
        chk("table_empty_after_reset", 64'(table_full), 64'(0));
        chk("drop_cleared", 64'(drop_count), 64'(0));
        pkt = '{8'h01, 8'h02, 8'h03};
        run_pkt(32'hA5A5_0001, 1);
        chk("post_reset_new", 64'(ld_new[ld_new.size() - 1]), 64'(1));

        chk("no_output_collisions", 64'(collide), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_dispatch.md
STREAM_DISPATCH -- requirements
Module: stream_dispatch

Interface
REQ-001 Parameter EOP_DELAY, default 3: cycles between the last char_in_vld and the eop pulse, covering the matcher's output pipeline; legal range 2..15.
REQ-002 Parameter NUM_STREAMS, default 64: flow-table depth; fixed to match the 6-bit stream_id.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 in_vld  in  1  input beat valid.
REQ-006 in_ready  out  1  input beat accepted when in_vld and in_ready are both high.
REQ-007 in_data  in  8  packet byte; every beat, including the sop beat, carries one byte.
REQ-008 in_sop  in  1  first beat of a packet.
REQ-009 in_eop  in  1  last beat of a packet; may coincide with in_sop.
REQ-010 in_key  in  32  flow key; sampled only on the accepted sop beat.
REQ-011 load_state  out  1  one-cycle pulse: matchers restore or clear state for stream_id.
REQ-012 new_stream_id  out  1  qualifies load_state: the flow was just allocated, so matchers clear state.
REQ-013 stream_id  out  6  flow index; stable from load_state through eop inclusive.
REQ-014 char_in  out  8  byte to the matchers.
REQ-015 char_in_vld  out  1  char_in valid.
REQ-016 eop  out  1  one-cycle pulse: matchers commit count and save state.
REQ-017 table_full  out  1  all NUM_STREAMS entries are valid.
REQ-018 drop_count  out  16  non-sop beats discarded in IDLE; wraps.

Function
REQ-019 FSM states: IDLE, LOOKUP, LOAD, GAP, STREAM, DRAIN, EOP.
REQ-020 IDLE: in_ready=1.
  - Accepted beat with in_sop: capture in_key, in_data and in_eop, then go to LOOKUP.
  - Accepted beat without in_sop: discard it and increment drop_count.
REQ-021 LOOKUP: in_ready=0; compare the captured key in parallel against all valid entries.
  - Hit: the index of the matching entry becomes stream_id.
  - Miss: alloc_ptr becomes stream_id; write the key there; set valid; alloc_ptr increments modulo 64.
REQ-022 On a miss with table_full=1, the entry at alloc_ptr is overwritten (round-robin eviction) and new_stream_id is still asserted.
REQ-023 Multiple hits are impossible by construction; keys are unique because allocation happens only on a miss.
REQ-024 LOAD: load_state=1 for exactly one cycle; new_stream_id=1 in the same cycle if LOOKUP missed, else 0; then go to GAP.
REQ-025 GAP: one idle cycle, so the first char_in_vld occurs exactly 2 cycles after load_state.
REQ-026 STREAM, first cycle: drive the stashed sop byte with char_in_vld=1.
  - If the stashed in_eop is 1, go to DRAIN.
  - Otherwise in_ready=1 from this cycle onward.
REQ-027 STREAM, later cycles: an accepted beat at cycle c drives char_in/char_in_vld at c+1; char_in_vld=0 when no beat was accepted.
  - An accepted beat with in_eop causes DRAIN to follow the cycle that outputs that byte.
REQ-028 An accepted beat with in_sop while in STREAM is treated as a data byte (the protocol violation is ignored).
REQ-029 DRAIN: in_ready=0; a counter loads EOP_DELAY-1 and decrements; at zero go to EOP.
  - Net effect: eop rises exactly EOP_DELAY cycles after the last char_in_vld.
REQ-030 EOP: eop=1 for one cycle; then go to IDLE.
REQ-031 Outputs are registered and the fixed timing holds regardless of in_vld gaps.
  - Single-byte packet: sop-beat accept at A; load_state A+2; char_in_vld A+4; eop A+4+EOP_DELAY.
REQ-032 load_state, eop and char_in_vld are never asserted in the same cycle.

Reset
REQ-033 With rst_n=0 at a clock edge:
  - FSM goes to IDLE and all table valid bits clear.
  - alloc_ptr=0 and drop_count=0.
  - in_ready, load_state, new_stream_id, char_in_vld, eop and table_full go to 0.
  - stream_id and char_in go to 0.
REQ-034 A reset during any state abandons the packet without issuing eop; the next accepted beat is treated from IDLE.

Verification
REQ-035 Key 0xA5A5_0001, 4-byte packet into an empty table -> load_state with new_stream_id=1 and stream_id=0; 4 char_in_vld cycles; eop EOP_DELAY cycles after the last byte.
REQ-036 Same key again -> new_stream_id=0, stream_id=0; a new key -> stream_id=1, new_stream_id=1.
REQ-037 Allocate 64 distinct keys -> table_full=1; 65th new key -> stream_id=0 (evicted), new_stream_id=1; the original key 0 now misses.
REQ-038 Single-beat packet (sop=eop) accepted at A -> load_state A+2, char_in_vld A+4 only, eop A+4+EOP_DELAY.
REQ-039 Three non-sop beats in IDLE -> drop_count=3, no outputs; random in_vld gaps within a packet -> byte order preserved, no extra char_in_vld.
REQ-040 rst_n low in STREAM -> no eop; table empty; the previously known key returns new_stream_id=1.
